// File: rtl/mod_case_pkg.sv
// Shared types for the request-to-code priority encoder.
package mod_case_pkg;
  localparam int CODE_W  = 3;
  localparam int NUM_REQ = 8;

  typedef enum logic [0:0] {IDLE, OFFER} enc_state_t;
  typedef logic [CODE_W-1:0] code_t;
endpackage

// File: rtl/mod_case_prio_sel.sv
// Combinational eligible-vector to code/multi/any selector.
// Build option MOD_CASE_ROUND_ROBIN_EN adds a rotate pointer input.
module mod_case_prio_sel
  import mod_case_pkg::*;
(
  input  logic [NUM_REQ-1:0] elig,
`ifdef MOD_CASE_ROUND_ROBIN_EN
  input  code_t              ptr,
`endif
  output code_t              code,
  output logic               multi,
  output logic               any
);

  logic [NUM_REQ-1:0] vec;
  code_t              off;

  always_comb begin
`ifdef MOD_CASE_ROUND_ROBIN_EN
    // Rotate so the pointer position becomes bit 0, then take the lowest bit.
    vec = NUM_REQ'({elig, elig} >> ptr);
`else
    vec = elig;
`endif
    off = '0;
    if ($countones(vec) == 1) begin
      unique case (vec)
        8'b0000_0001: off = 3'd0;
        8'b0000_0010: off = 3'd1;
        8'b0000_0100: off = 3'd2;
        8'b0000_1000: off = 3'd3;
        8'b0001_0000: off = 3'd4;
        8'b0010_0000: off = 3'd5;
        8'b0100_0000: off = 3'd6;
        8'b1000_0000: off = 3'd7;
        default:      off = 3'd0;
      endcase
    end else begin
      priority casez (vec)
        8'b????_???1: off = 3'd0;
        8'b????_??10: off = 3'd1;
        8'b????_?100: off = 3'd2;
        8'b????_1000: off = 3'd3;
        8'b???1_0000: off = 3'd4;
        8'b??10_0000: off = 3'd5;
        8'b?100_0000: off = 3'd6;
        8'b1000_0000: off = 3'd7;
        default:      off = 3'd0;
      endcase
    end
`ifdef MOD_CASE_ROUND_ROBIN_EN
    code = code_t'(off + ptr);
`else
    code = off;
`endif
  end

  assign multi = ($countones(elig) > 1);
  assign any   = |elig;

endmodule

// File: rtl/mod_case_priority_encoder.sv
// Sticky-request priority encoder offering a 3-bit code over valid/ready.
// Build option MOD_CASE_ROUND_ROBIN_EN selects rotating instead of fixed priority.
module mod_case_priority_encoder
  import mod_case_pkg::*;
#(
  parameter int CODE_W  = 3,
  parameter int NUM_REQ = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] in_req,
  input  logic [NUM_REQ-1:0] in_mask,
  input  logic               in_ready,
  output logic               out_valid,
  output logic [CODE_W-1:0]  out_code,
  output logic               out_multi,
  output logic [NUM_REQ-1:0] out_pending,
  output logic [CNT_W-1:0]   out_grant_cnt
);

  enc_state_t         state;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] granted;
  logic [NUM_REQ-1:0] sel_vec;
  logic               accept;
  code_t              sel_code;
  logic               sel_multi;
  logic               sel_any;

  assign elig    = out_pending & ~in_mask;
  assign accept  = (state == OFFER) && in_ready;
  assign granted = accept ? (NUM_REQ'(1) << out_code) : '0;
  // The just-granted bit is excluded so back-to-back offers move on.
  assign sel_vec = elig & ~granted;

`ifdef MOD_CASE_ROUND_ROBIN_EN
  code_t ptr;
  code_t sel_ptr;

  assign sel_ptr = accept ? code_t'(out_code + 1'b1) : ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= code_t'(out_code + 1'b1);
    end
  end

  mod_case_prio_sel u_sel (
    .elig  (sel_vec),
    .ptr   (sel_ptr),
    .code  (sel_code),
    .multi (sel_multi),
    .any   (sel_any)
  );
`else
  mod_case_prio_sel u_sel (
    .elig  (sel_vec),
    .code  (sel_code),
    .multi (sel_multi),
    .any   (sel_any)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      out_valid     <= 1'b0;
      out_code      <= '0;
      out_multi     <= 1'b0;
      out_pending   <= '0;
      out_grant_cnt <= '0;
    end else begin
      // A request arriving on the bit being cleared keeps it pending.
      out_pending <= (out_pending & ~granted) | in_req;
      case (state)
        IDLE: begin
          if (sel_any) begin
            out_code  <= sel_code;
            out_multi <= sel_multi;
            out_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (in_ready) begin
            out_grant_cnt <= out_grant_cnt + CNT_W'(1);
            if (sel_any) begin
              out_code  <= sel_code;
              out_multi <= sel_multi;
            end else begin
              out_valid <= 1'b0;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_case_priority_encoder.sv
// Self-checking bench: directed vector table, hand sequences and a random run against a reference model.
module tb_mod_case_priority_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_req;
  logic [7:0] in_mask;
  logic       in_ready;
  logic       out_valid;
  logic [2:0] out_code;
  logic       out_multi;
  logic [7:0] out_pending;
  logic [7:0] out_grant_cnt;

  int checks = 0;
  int errors = 0;

  mod_case_priority_encoder #(.CODE_W(3), .NUM_REQ(8), .CNT_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_req        (in_req),
    .in_mask       (in_mask),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_code      (out_code),
    .out_multi     (out_multi),
    .out_pending   (out_pending),
    .out_grant_cnt (out_grant_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rstn;
    logic [7:0] req;
    logic [7:0] mask;
    logic       rdy;
    logic       val;
    logic [2:0] code;
    logic       mul;
    logic [7:0] pend;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];

  // Reference model state: request bits, current offer, counter, rotate start.
  bit   m_pend[8];
  bit   m_valid;
  int   m_code;
  bit   m_multi;
  int   m_cnt;
  int   m_ptr;

  task automatic add(input logic rstn, input logic [7:0] req, input logic [7:0] mask,
                     input logic rdy, input logic val, input logic [2:0] code,
                     input logic mul, input logic [7:0] pend, input logic [7:0] cnt);
    tbl.push_back({rstn, req, mask, rdy, val, code, mul, pend, cnt});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rstn, input logic [7:0] req,
                            input logic [7:0] mask, input logic rdy);
    bit accept;
    bit cand[8];
    int n;
    int pick;
    int start;
    if (!rstn) begin
      foreach (m_pend[i]) m_pend[i] = 0;
      m_valid = 0; m_code = 0; m_multi = 0; m_cnt = 0; m_ptr = 0;
      return;
    end
    accept = m_valid && rdy;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      cand[i] = m_pend[i] && !mask[i] && !(accept && i == m_code);
      if (cand[i]) n++;
    end
`ifdef MOD_CASE_ROUND_ROBIN_EN
    start = accept ? (m_code + 1) % 8 : m_ptr;
`else
    start = 0;
`endif
    pick = -1;
    for (int k = 0; k < 8; k++)
      if (pick < 0 && cand[(start + k) % 8]) pick = (start + k) % 8;
    for (int i = 0; i < 8; i++)
      m_pend[i] = (m_pend[i] && !(accept && i == m_code)) || req[i];
    if (!m_valid) begin
      if (n > 0) begin
        m_valid = 1; m_code = pick; m_multi = (n > 1);
      end
    end else if (accept) begin
      m_cnt = (m_cnt + 1) % 256;
      m_ptr = (m_code + 1) % 8;
      if (n > 0) begin
        m_code = pick; m_multi = (n > 1);
      end else begin
        m_valid = 0;
      end
    end
  endtask

  function automatic logic [7:0] model_pend();
    logic [7:0] p;
    for (int i = 0; i < 8; i++) p[i] = m_pend[i];
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(rst_n, in_req, in_mask, in_ready);
    #1;
  endtask

  task automatic drive(input logic rstn, input logic [7:0] req,
                       input logic [7:0] mask, input logic rdy);
    rst_n = rstn; in_req = req; in_mask = mask; in_ready = rdy;
  endtask

  initial begin
    int acc;
    int cyc;
    int codes[$];
    drive(1'b0, 8'h00, 8'h00, 1'b0);

    // rstn req mask rdy | val code mul pend cnt
    add(0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) add(1, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0);
    add(1, 8'h24, 8'h00, 1, 0, 0, 0, 8'h24, 0);
    add(1, 8'h00, 8'h00, 1, 1, 2, 1, 8'h24, 0);
    add(1, 8'h00, 8'h00, 1, 1, 5, 0, 8'h20, 1);
    add(1, 8'h00, 8'h00, 1, 0, 5, 0, 8'h00, 2);
    add(1, 8'h00, 8'h00, 0, 0, 5, 0, 8'h00, 2);
    add(1, 8'h08, 8'h00, 0, 0, 5, 0, 8'h08, 2);
    add(1, 8'h00, 8'h00, 0, 1, 3, 0, 8'h08, 2);
    add(1, 8'h00, 8'h00, 0, 1, 3, 0, 8'h08, 2);
    add(1, 8'h00, 8'hFF, 0, 1, 3, 0, 8'h08, 2);
    add(1, 8'h00, 8'h00, 0, 1, 3, 0, 8'h08, 2);
    add(1, 8'h00, 8'h00, 1, 0, 3, 0, 8'h00, 3);
    add(1, 8'h00, 8'h00, 0, 0, 3, 0, 8'h00, 3);
    add(1, 8'h01, 8'h00, 0, 0, 3, 0, 8'h01, 3);
    add(1, 8'h00, 8'h00, 0, 1, 0, 0, 8'h01, 3);
    add(1, 8'h01, 8'h00, 1, 0, 0, 0, 8'h01, 4);
    add(1, 8'h00, 8'h00, 1, 1, 0, 0, 8'h01, 4);
    add(1, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 5);
    add(1, 8'h81, 8'hFF, 1, 0, 0, 0, 8'h81, 5);
    add(1, 8'h00, 8'hFF, 1, 0, 0, 0, 8'h81, 5);
    add(1, 8'h00, 8'hFF, 1, 0, 0, 0, 8'h81, 5);
    add(1, 8'h00, 8'h01, 0, 1, 7, 0, 8'h81, 5);
    add(1, 8'h00, 8'h01, 1, 0, 7, 0, 8'h01, 6);
    add(1, 8'h00, 8'h00, 0, 1, 0, 0, 8'h01, 6);
    add(1, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 7);

    #2;
    foreach (tbl[r]) begin
      drive(tbl[r].rstn, tbl[r].req, tbl[r].mask, tbl[r].rdy);
      tick();
      chk($sformatf("tbl%0d_valid", r), out_valid, tbl[r].val);
      chk($sformatf("tbl%0d_code", r), out_code, tbl[r].code);
      chk($sformatf("tbl%0d_multi", r), out_multi, tbl[r].mul);
      chk($sformatf("tbl%0d_pending", r), out_pending, tbl[r].pend);
      chk($sformatf("tbl%0d_cnt", r), out_grant_cnt, tbl[r].cnt);
    end

    // Counter wrap with every request held high and the consumer always ready.
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    drive(1'b1, 8'hFF, 8'h00, 1'b1);
    acc = 0;
    cyc = 0;
    while (acc < 256 && cyc < 1000) begin
      if (out_valid && in_ready) acc++;
      tick();
      cyc++;
      if (acc == 255 && out_valid && in_ready) chk("cnt_at_255", out_grant_cnt, 8'd255);
    end
    chk("wrap_accepts", acc, 256);
    chk("wrap_cnt", out_grant_cnt, 8'd0);
    chk("wrap_offer_live", out_valid, 1'b1);

    // Reset during an offer drops it; requests are ignored while in reset.
    drive(1'b0, 8'hFF, 8'h00, 1'b1);
    tick();
    chk("rst_mid_valid", out_valid, 1'b0);
    chk("rst_mid_cnt", out_grant_cnt, 8'd0);
    chk("rst_mid_pend", out_pending, 8'h00);
    tick();
    chk("rst_hold_pend", out_pending, 8'h00);

    // Two constant requests are granted alternately.
    drive(1'b1, 8'h03, 8'h00, 1'b1);
    cyc = 0;
    while (codes.size() < 8 && cyc < 40) begin
      if (out_valid && in_ready) codes.push_back(int'(out_code));
      tick();
      cyc++;
    end
    chk("alt_count", codes.size(), 8);
    foreach (codes[i]) chk($sformatf("alt_code%0d", i), codes[i], i % 2);

    // Random traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 99) != 0),
            8'($urandom & $urandom & $urandom),
            ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
            1'($urandom_range(0, 1)));
      tick();
      chk("rnd_valid", out_valid, m_valid);
      chk("rnd_code", out_code, m_code);
      chk("rnd_multi", out_multi, m_multi);
      chk("rnd_pending", out_pending, model_pend());
      chk("rnd_cnt", out_grant_cnt, m_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
